// File: rtl/sm3_pkg.sv
// sm3_pkg: shared SM3 constants, scheduler state encoding and round helper functions.
//   SM3_IV       - initial chaining value A..H
//   SM3_RND_NUM  - compression rounds per block
//   SM3_BLK_WRDS - 32-bit words per 512-bit block
//   rotl32/p0/p1 - 32-bit rotate and the two SM3 permutations
package sm3_pkg;

    localparam logic [255:0] SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam int unsigned SM3_RND_NUM  = 64;
    localparam int unsigned SM3_BLK_WRDS = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StExpnd,
        StGap,
        StWaitRes,
        StHold
    } sm3_state_e;

    // n == 0 works because a shift by the full width yields zero.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl32(x, 9) ^ rotl32(x, 17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl32(x, 15) ^ rotl32(x, 23);
    endfunction

endpackage

// File: rtl/sm3_expnd_win.sv
// sm3_expnd_win: 16-word message window with on-the-fly W_{j+16} generation.
//   clk, rst     - clock, asynchronous active-high reset
//   clr_i        - synchronous clear of the whole window
//   ld_i, wrd_i  - shift a message word into win[15]
//   shft_i       - shift one round, generated word enters win[15]
//   wj_o, wjj_o  - W_j = win[0] and W'_j = win[0] ^ win[4]
module sm3_expnd_win
    import sm3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        ld_i,
    input  logic [31:0] wrd_i,
    input  logic        shft_i,
    output logic [31:0] wj_o,
    output logic [31:0] wjj_o
);

    logic [31:0] win_q [SM3_BLK_WRDS];
    logic [31:0] win_d [SM3_BLK_WRDS];
    logic [31:0] w_new;

    // With win[0] = W_j this is W_{j+16}.
    assign w_new = p1(win_q[0] ^ win_q[7] ^ rotl32(win_q[13], 15))
                 ^ rotl32(win_q[3], 7) ^ win_q[10];

    always_comb begin
        win_d = win_q;
        if (clr_i) begin
            for (int i = 0; i < SM3_BLK_WRDS; i++) begin
                win_d[i] = '0;
            end
        end else if (ld_i || shft_i) begin
            for (int i = 0; i < SM3_BLK_WRDS - 1; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[SM3_BLK_WRDS - 1] = ld_i ? wrd_i : w_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SM3_BLK_WRDS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            win_q <= win_d;
        end
    end

    assign wj_o  = win_q[0];
    assign wjj_o = win_q[0] ^ win_q[4];

endmodule

// File: rtl/sm3_blk_sched.sv
// sm3_blk_sched: SM3 front-end scheduler. Buffers one 16-word block from a valid/ready stream,
// streams 64 (W_j, W'_j) pairs to the compression core, spaces blocks by BLK_GAP idle cycles
// and holds the final digest until acknowledged.
//   clk, rst                  - clock, asynchronous active-high reset
//   sw_clr_i                  - synchronous abort to IDLE (core must be reset alongside it)
//   msg_wrd_i/vld_i/lst_i     - padded message words; lst marks word 16 of the final block
//   msg_rdy_o                 - word accepted when msg_vld_i && msg_rdy_o
//   expnd_wj_o/wjj_o/vld_o/lst_o - round stream to the core
//   cmprss_res_i/vld_i        - core digest and its valid pulse
//   res_o/res_vld_o/res_rdy_i - held digest handshake
//   busy_o                    - not IDLE
module sm3_blk_sched
    import sm3_pkg::*;
#(
    parameter int unsigned BLK_GAP = 2,  // >= 2: block-finish XOR must not meet a new round
    parameter int unsigned RND_NUM = SM3_RND_NUM
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sw_clr_i,
    input  logic [31:0]  msg_wrd_i,
    input  logic         msg_vld_i,
    input  logic         msg_lst_i,
    output logic         msg_rdy_o,
    output logic [31:0]  expnd_wj_o,
    output logic [31:0]  expnd_wjj_o,
    output logic         expnd_vld_o,
    output logic         expnd_lst_o,
    input  logic [255:0] cmprss_res_i,
    input  logic         cmprss_vld_i,
    output logic [255:0] res_o,
    output logic         res_vld_o,
    input  logic         res_rdy_i,
    output logic         busy_o
);

    localparam int unsigned     RndW    = $clog2(RND_NUM);
    localparam int unsigned     GapW    = $clog2(BLK_GAP + 1);
    localparam logic [RndW-1:0] RndLast = RndW'(RND_NUM - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(BLK_GAP - 1);
    localparam logic [3:0]      WrdLast = 4'(SM3_BLK_WRDS - 1);

    sm3_state_e      state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [RndW-1:0] rnd_q, rnd_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            lst_q, lst_d;
    logic [255:0]    res_q, res_d;
    logic            res_vld_q, res_vld_d;
    logic            rdy_q, rdy_d;
    logic            acc;
    logic [31:0]     wj, wjj;

    // rdy_q only reads high in IDLE/LOAD, so an accepted word is always a load.
    assign acc = msg_vld_i && rdy_q;

    sm3_expnd_win u_win (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (sw_clr_i),
        .ld_i   (acc),
        .wrd_i  (msg_wrd_i),
        .shft_i (state_q == StExpnd),
        .wj_o   (wj),
        .wjj_o  (wjj)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wcnt_q    <= '0;
            rnd_q     <= '0;
            gap_q     <= '0;
            lst_q     <= 1'b0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rnd_q     <= rnd_d;
            gap_q     <= gap_d;
            lst_q     <= lst_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            rdy_q     <= rdy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rnd_d     = rnd_q;
        gap_d     = gap_q;
        lst_d     = lst_q;
        res_d     = res_q;
        res_vld_d = res_vld_q;
        unique case (state_q)
            StIdle: begin
                if (acc) begin
                    wcnt_d  = 4'd1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (acc) begin
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == WrdLast) begin
                        lst_d   = msg_lst_i;
                        rnd_d   = '0;
                        state_d = StExpnd;
                    end
                end
            end
            StExpnd: begin
                rnd_d = rnd_q + 1'b1;
                gap_d = '0;
                if (rnd_q == RndLast) begin
                    state_d = lst_q ? StWaitRes : StGap;
                end
            end
            StGap: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GapLast) begin
                    state_d = StLoad;
                end
            end
            StWaitRes: begin
                if (cmprss_vld_i) begin
                    res_d     = cmprss_res_i;
                    res_vld_d = 1'b1;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (res_rdy_i) begin
                    res_vld_d = 1'b0;
                    lst_d     = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (sw_clr_i) begin
            state_d   = StIdle;
            wcnt_d    = '0;
            rnd_d     = '0;
            gap_d     = '0;
            lst_d     = 1'b0;
            res_vld_d = 1'b0;
        end
        // Registered ready keeps msg_rdy_o low while rst is asserted.
        rdy_d = (state_d == StIdle) || (state_d == StLoad);
    end

    always_comb begin
        msg_rdy_o   = rdy_q;
        expnd_vld_o = (state_q == StExpnd);
        expnd_lst_o = expnd_vld_o && lst_q && (rnd_q == RndLast);
        expnd_wj_o  = expnd_vld_o ? wj  : '0;
        expnd_wjj_o = expnd_vld_o ? wjj : '0;
        res_o       = res_q;
        res_vld_o   = res_vld_q;
        busy_o      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_sm3_blk_sched.sv
// tb_sm3_blk_sched: directed bench for sm3_blk_sched. A behavioural SM3 core consumes the round
// stream and returns the chained digest, so the known digests check all 64 rounds per block.
module tb_sm3_blk_sched;
    import sm3_pkg::*;

    localparam int unsigned  BLK_GAP  = 2;
    localparam logic [255:0] DIG_ABC  =
        256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] DIG_ABCD =
        256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
    localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_D1   = {16{32'h61626364}};
    localparam logic [511:0] BLK_D2   = {32'h80000000, 448'h0, 32'h00000200};

    logic         clk = 1'b0;
    logic         rst;
    logic         sw_clr_i;
    logic [31:0]  msg_wrd_i;
    logic         msg_vld_i;
    logic         msg_lst_i;
    logic         msg_rdy_o;
    logic [31:0]  expnd_wj_o;
    logic [31:0]  expnd_wjj_o;
    logic         expnd_vld_o;
    logic         expnd_lst_o;
    logic [255:0] cmprss_res_i = '0;
    logic         cmprss_vld_i = 1'b0;
    logic [255:0] res_o;
    logic         res_vld_o;
    logic         res_rdy_i;
    logic         busy_o;

    always #5 clk = ~clk;

    sm3_blk_sched #(
        .BLK_GAP (BLK_GAP),
        .RND_NUM (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_clr_i     (sw_clr_i),
        .msg_wrd_i    (msg_wrd_i),
        .msg_vld_i    (msg_vld_i),
        .msg_lst_i    (msg_lst_i),
        .msg_rdy_o    (msg_rdy_o),
        .expnd_wj_o   (expnd_wj_o),
        .expnd_wjj_o  (expnd_wjj_o),
        .expnd_vld_o  (expnd_vld_o),
        .expnd_lst_o  (expnd_lst_o),
        .cmprss_res_i (cmprss_res_i),
        .cmprss_vld_i (cmprss_vld_i),
        .res_o        (res_o),
        .res_vld_o    (res_vld_o),
        .res_rdy_i    (res_rdy_i),
        .busy_o       (busy_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural core + stream monitor ----------------
    logic [255:0] m_v = SM3_IV;
    logic [255:0] m_dig = '0;
    logic [31:0]  ra, rb, rc, rd, re, rf, rg, rh;
    int           m_rnd = 0;
    int           fire_cnt = 0;
    int           log_n = 0;
    logic [31:0]  wj_log  [512];
    logic [31:0]  wjj_log [512];
    logic         lst_log [512];
    int           core_rst_req = 0, core_rst_done = 0;
    int           spur_req = 0, spur_done = 0;
    bit           gap_arm = 1'b0;
    int           gap_cnt = 0;
    int           gap_meas = -1;
    int           rdy_viol = 0;

    task automatic sm3_round(input int j, input logic [31:0] wj, input logic [31:0] wjj);
        logic [31:0] t, ss1, ss2, ff, gg, tt1, tt2;
        t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
        ss1 = rotl32(rotl32(ra, 12) + re + rotl32(t, j % 32), 7);
        ss2 = ss1 ^ rotl32(ra, 12);
        ff  = (j < 16) ? (ra ^ rb ^ rc) : ((ra & rb) | (ra & rc) | (rb & rc));
        gg  = (j < 16) ? (re ^ rf ^ rg) : ((re & rf) | (~re & rg));
        tt1 = ff + rd + ss2 + wjj;
        tt2 = gg + rh + ss1 + wj;
        rd = rc; rc = rotl32(rb, 9); rb = ra; ra = tt1;
        rh = rg; rg = rotl32(rf, 19); rf = re; re = p0(tt2);
    endtask

    always @(negedge clk) begin
        if (core_rst_req != core_rst_done) begin
            core_rst_done = core_rst_req;
            m_v = SM3_IV;
            m_rnd = 0;
            fire_cnt = 0;
        end
        if (msg_rdy_o && (expnd_vld_o || res_vld_o || fire_cnt > 0)) rdy_viol++;
        cmprss_vld_i = 1'b0;
        if (expnd_vld_o) begin
            if (m_rnd == 0) {ra, rb, rc, rd, re, rf, rg, rh} = m_v;
            sm3_round(m_rnd, expnd_wj_o, expnd_wjj_o);
            if (log_n < 512) begin
                wj_log[log_n]  = expnd_wj_o;
                wjj_log[log_n] = expnd_wjj_o;
                lst_log[log_n] = expnd_lst_o;
                log_n++;
            end
            if (m_rnd == 63) begin
                m_v = {ra, rb, rc, rd, re, rf, rg, rh} ^ m_v;
                m_rnd = 0;
                gap_arm = !expnd_lst_o;
                gap_cnt = 0;
                if (expnd_lst_o) begin
                    m_dig = m_v;
                    m_v = SM3_IV;
                    fire_cnt = 2;
                end
            end else begin
                m_rnd++;
            end
        end else if (gap_arm) begin
            if (msg_rdy_o) begin
                gap_meas = gap_cnt;
                gap_arm = 1'b0;
            end else begin
                gap_cnt++;
            end
        end
        if (fire_cnt > 0) begin
            fire_cnt--;
            if (fire_cnt == 0) begin
                cmprss_vld_i = 1'b1;
                cmprss_res_i = m_dig;
            end
        end
        if (spur_req != spur_done) begin
            spur_done = spur_req;
            cmprss_vld_i = 1'b1;
            cmprss_res_i = '1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_word(input logic [31:0] w, input logic l, input bit gaps);
        int t;
        if (gaps) begin
            msg_vld_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        msg_wrd_i = w;
        msg_lst_i = l;
        msg_vld_i = 1'b1;
        t = 0;
        while (!msg_rdy_o && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("send_word msg_rdy_o", msg_rdy_o, 1'b1);
        @(negedge clk);
        msg_vld_i = 1'b0;
        msg_lst_i = 1'b0;
    endtask

    // In gap mode msg_lst_i is also raised on word 5, which must be ignored.
    task automatic send_block(input logic [511:0] blk, input logic last, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            send_word(blk[511 - 32*i -: 32], (i == 15) ? last : (gaps && i == 4), gaps);
        end
    endtask

    task automatic wait_res(input string name);
        int t = 0;
        while (!res_vld_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({name, " res_vld_o"}, res_vld_o, 1'b1);
    endtask

    task automatic release_res(input string name);
        res_rdy_i = 1'b1;
        @(negedge clk);
        res_rdy_i = 1'b0;
        chk({name, " busy_o after ack"}, busy_o, 1'b0);
        chk({name, " res_vld_o after ack"}, res_vld_o, 1'b0);
    endtask

    typedef struct {
        int unsigned off;
        logic [31:0] wj;
        logic [31:0] wjj;
        bit          has_wjj;
    } rnd_vec_t;

    rnd_vec_t abc_vec [8];
    rnd_vec_t two_vec [3];

    initial begin
        int b1, b2, b3, b5, cnt, bad;

        abc_vec[0] = '{0,  32'h61626380, 32'h61626380, 1'b1};
        abc_vec[1] = '{1,  32'h00000000, 32'h00000000, 1'b1};
        abc_vec[2] = '{11, 32'h00000000, 32'h00000018, 1'b1};
        abc_vec[3] = '{12, 32'h00000000, 32'h9092e200, 1'b1};
        abc_vec[4] = '{14, 32'h00000000, 32'h000c0606, 1'b1};
        abc_vec[5] = '{15, 32'h00000018, 32'h00000000, 1'b0};
        abc_vec[6] = '{16, 32'h9092e200, 32'h00000000, 1'b0};
        abc_vec[7] = '{18, 32'h000c0606, 32'h00000000, 1'b0};
        two_vec[0] = '{0,  32'h61626364, 32'h00000000, 1'b1};
        two_vec[1] = '{15, 32'h61626364, 32'h00000000, 1'b0};
        two_vec[2] = '{64, 32'h80000000, 32'h80000000, 1'b1};

        rst = 1'b1;
        sw_clr_i = 1'b0;
        msg_wrd_i = '0;
        msg_vld_i = 1'b0;
        msg_lst_i = 1'b0;
        res_rdy_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset ctrl outputs", {msg_rdy_o, expnd_vld_o, expnd_lst_o, res_vld_o, busy_o}, '0);
        chk("reset res_o", res_o, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle msg_rdy_o", msg_rdy_o, 1'b1);

        // 1: "abc"
        b1 = log_n;
        send_block(BLK_ABC, 1'b1, 1'b0);
        wait_res("abc");
        chk("abc digest", res_o, DIG_ABC);
        chk("abc round count", 32'(log_n - b1), 32'd64);
        foreach (abc_vec[k]) begin
            chk($sformatf("abc wj r%0d", abc_vec[k].off), wj_log[b1 + abc_vec[k].off],
                abc_vec[k].wj);
            if (abc_vec[k].has_wjj)
                chk($sformatf("abc wjj r%0d", abc_vec[k].off), wjj_log[b1 + abc_vec[k].off],
                    abc_vec[k].wjj);
        end
        cnt = 0;
        for (int i = 0; i < 63; i++) if (lst_log[b1 + i]) cnt++;
        chk("abc lst before r63", 32'(cnt), 32'd0);
        chk("abc lst at r63", lst_log[b1 + 63], 1'b1);

        // 4: digest held while res_rdy_i stays low
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_vld_o !== 1'b1 || res_o !== DIG_ABC) bad++;
        end
        chk("hold stable cycles bad", 32'(bad), 32'd0);
        release_res("hold");

        // 2: two-block message
        b2 = log_n;
        send_block(BLK_D1, 1'b0, 1'b0);
        send_block(BLK_D2, 1'b1, 1'b0);
        wait_res("abcd16");
        chk("abcd16 digest", res_o, DIG_ABCD);
        chk("abcd16 round count", 32'(log_n - b2), 32'd128);
        chk("abcd16 gap cycles", 32'(gap_meas), 32'(BLK_GAP));
        foreach (two_vec[k]) begin
            chk($sformatf("abcd16 wj i%0d", two_vec[k].off), wj_log[b2 + two_vec[k].off],
                two_vec[k].wj);
            if (two_vec[k].has_wjj)
                chk($sformatf("abcd16 wjj i%0d", two_vec[k].off), wjj_log[b2 + two_vec[k].off],
                    two_vec[k].wjj);
        end
        cnt = 0;
        for (int i = 0; i < 127; i++) if (lst_log[b2 + i]) cnt++;
        chk("abcd16 lst before last", 32'(cnt), 32'd0);
        chk("abcd16 lst at last", lst_log[b2 + 127], 1'b1);
        release_res("abcd16");

        // 3: "abc" with source gaps
        b3 = log_n;
        send_block(BLK_ABC, 1'b1, 1'b1);
        wait_res("gappy");
        chk("gappy digest", res_o, DIG_ABC);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (wj_log[b3 + i] !== wj_log[b1 + i] || wjj_log[b3 + i] !== wjj_log[b1 + i]) bad++;
        end
        chk("gappy stream diffs", 32'(bad), 32'd0);
        release_res("gappy");

        // 5: abort at round 30
        b5 = log_n;
        send_block(BLK_ABC, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        sw_clr_i = 1'b1;
        @(negedge clk);
        sw_clr_i = 1'b0;
        chk("clr expnd_vld_o", expnd_vld_o, 1'b0);
        chk("clr busy_o", busy_o, 1'b0);
        chk("clr res_vld_o", res_vld_o, 1'b0);
        chk("clr rounds sent", 32'(log_n - b5), 32'd31);
        @(negedge clk);
        chk("clr msg_rdy_o", msg_rdy_o, 1'b1);
        core_rst_req++;
        @(negedge clk);
        send_block(BLK_ABC, 1'b1, 1'b0);
        wait_res("resend");
        chk("resend digest", res_o, DIG_ABC);
        release_res("resend");

        // 6: async reset mid-LOAD, then a spurious core pulse in IDLE
        for (int i = 0; i < 5; i++) send_word(BLK_ABC[511 - 32*i -: 32], 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async rst ctrl outputs",
            {msg_rdy_o, expnd_vld_o, expnd_lst_o, res_vld_o, busy_o}, '0);
        chk("async rst res_o", res_o, '0);
        @(negedge clk);
        rst = 1'b0;
        core_rst_req++;
        spur_req++;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (res_vld_o) bad++;
        end
        chk("spurious res_vld_o cycles", 32'(bad), 32'd0);
        chk("spurious res_o", res_o, '0);
        chk("post rst busy_o", busy_o, 1'b0);

        chk("msg_rdy_o outside LOAD/IDLE", 32'(rdy_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d",
                 n_chk, n_err);
        $fatal(1, "watchdog");
    end

endmodule
